// File: rtl/vblank_mem_scheduler_if.sv
// Raster position, request/done handshake and ownership status between the
// game-logic engines, VGA timing and the vertical-blanking memory scheduler.
interface vblank_mem_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [9:0]         colPos;
  logic [9:0]         rowPos;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic               mem_owner_game;
  logic               frame_tick;
  logic               abort;
  logic [15:0]        frame_count;

  // Timing generator and engines drive raster/requests, observe grants.
  modport master (
    output colPos, rowPos, req, done,
    input  gnt, mem_owner_game, frame_tick, abort, frame_count
  );

  // Scheduler side.
  modport slave (
    input  colPos, rowPos, req, done,
    output gnt, mem_owner_game, frame_tick, abort, frame_count
  );
endinterface

// File: rtl/vblank_mem_scheduler.sv
// Hands the shared object/tile memory to one game-logic engine at a time,
// round-robin, during vertical blanking; the renderer owns it otherwise.
module vblank_mem_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  vblank_mem_scheduler_if.slave   bus
);
  localparam int unsigned ROW_W = 10;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST);
  localparam int unsigned FC_W  = 16;

  localparam logic [ROW_W-1:0] V_ACTIVE_ROW = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_RENDER = 2'd0,
    S_ARB    = 2'd1,
    S_GRANT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               blank_c, blank_q, blank_rise_c;
  logic               grant_ok_c, release_c;
  logic               req_cur_c, done_cur_c;
  logic [IDX_W-1:0]   win_c;
  logic               win_valid_c;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               owner_q;
  logic               abort_q, abort_d;
  logic               tick_q;
  logic [FC_W-1:0]    frame_count_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               unused_col_c;

  // Column position is not needed for row-granular scheduling.
  assign unused_col_c = ^bus.colPos;

  assign blank_c      = (bus.rowPos >= V_ACTIVE_ROW);
  assign blank_rise_c = blank_c & ~blank_q;
  // No new grant on the final line: it could not finish before active video.
  assign grant_ok_c   = (|bus.req) && (bus.rowPos != LAST_ROW);
  // Only the current owner's request/done bits matter.
  assign req_cur_c    = |(bus.req & gnt_q);
  assign done_cur_c   = |(bus.done & gnt_q);
  assign release_c    = done_cur_c | ~req_cur_c | (cnt_q == CNT_LAST);

  // Round-robin search starting just after the previous winner.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    win_c       = last_q;
    win_valid_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = int'(unsigned'(last_q)) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid_c && bus.req[IDX_W'(idx)]) begin
        win_c       = IDX_W'(idx);
        win_valid_c = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RENDER;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RENDER: if (blank_rise_c) state_d = S_ARB;
      S_ARB: begin
        if (!blank_c)                       state_d = S_RENDER;
        else if (grant_ok_c && win_valid_c) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (!blank_c)       state_d = S_RENDER;
        else if (release_c) state_d = S_ARB;
      end
      default: state_d = S_RENDER;
    endcase
  end

  // Grant, burst counter, abort and round-robin pointer next values.
  // The pointer moves at grant time; the owner cannot change until release,
  // so this is equivalent to recording the winner when it lets go.
  always_comb begin
    gnt_d   = '0;
    abort_d = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_ARB: begin
        if (blank_c && grant_ok_c && win_valid_c) begin
          gnt_d  = NUM_REQ'(1) << win_c;
          cnt_d  = '0;
          last_d = win_c;
        end
      end
      S_GRANT: begin
        if (!blank_c) begin
          abort_d = ~done_cur_c;
        end else if (!release_c) begin
          gnt_d = gnt_q;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q       <= 1'b1;
      gnt_q         <= '0;
      owner_q       <= 1'b0;
      abort_q       <= 1'b0;
      tick_q        <= 1'b0;
      frame_count_q <= '0;
      cnt_q         <= '0;
      last_q        <= IDX_LAST;
    end else begin
      blank_q       <= blank_c;
      gnt_q         <= gnt_d;
      owner_q       <= |gnt_d;
      abort_q       <= abort_d;
      tick_q        <= blank_rise_c;
      frame_count_q <= frame_count_q + FC_W'(blank_rise_c);
      cnt_q         <= cnt_d;
      last_q        <= last_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.mem_owner_game = owner_q;
  assign bus.frame_tick     = tick_q;
  assign bus.abort          = abort_q;
  assign bus.frame_count    = frame_count_q;
endmodule

// File: tb/tb_vblank_mem_scheduler.sv
// Directed scenarios plus random raster/request traffic against a
// behavioural ownership model of the vertical-blanking memory scheduler.
module tb_vblank_mem_scheduler;
  localparam int NR = 4;
  localparam int VA = 480;
  localparam int VT = 525;
  localparam int MB = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vblank_mem_scheduler_if #(.NUM_REQ(NR)) bus ();

  vblank_mem_scheduler #(
    .NUM_REQ(NR), .V_ACTIVE(VA), .V_TOTAL(VT), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: engine holding the memory (-1 none); window: inside a blanking
  // interval that opened after a seen blank rise; held: cycles owned so far.
  bit          chk_en = 1'b0;
  bit          m_prev_blank = 1'b1;
  bit          m_window = 1'b0;
  int          m_owner = -1;
  int          m_held = 0;
  int          m_last = NR - 1;
  bit          e_tick = 1'b0;
  bit          e_abort = 1'b0;
  logic [15:0] e_count = 16'd0;

  task automatic model_reset();
    m_prev_blank = 1'b1;
    m_window     = 1'b0;
    m_owner      = -1;
    m_held       = 0;
    m_last       = NR - 1;
    e_tick       = 1'b0;
    e_abort      = 1'b0;
    e_count      = 16'd0;
  endtask

  task automatic model_step();
    bit blank, rise;
    int row;
    row   = int'(bus.rowPos);
    blank = (row >= VA);
    rise  = blank && !m_prev_blank;
    e_tick  = rise;
    e_abort = 1'b0;
    if (rise) e_count = e_count + 16'd1;
    if (m_owner >= 0) begin
      m_held++;
      if (!blank) begin
        e_abort  = !bus.done[m_owner];
        m_last   = m_owner;
        m_owner  = -1;
        m_window = 1'b0;
      end else if (bus.done[m_owner] || !bus.req[m_owner] || m_held == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (m_window) begin
      if (!blank) m_window = 1'b0;
      else if (bus.req != '0 && row != VT - 1) begin
        for (int k = 1; k <= NR; k++) begin
          int i;
          i = (m_last + k) % NR;
          if (bus.req[i]) begin
            m_owner = i;
            m_held  = 0;
            break;
          end
        end
      end
    end else if (rise) begin
      m_window = 1'b1;
    end
    m_prev_blank = blank;
  endtask

  // Advance the model on each edge and compare every output just after it.
  always @(posedge clk or posedge reset) begin
    logic [3:0] eg;
    if (reset) model_reset();
    else       model_step();
    #1;
    if (chk_en) begin
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      check("gnt", 32'(bus.gnt), 32'(eg));
      check("mem_owner_game", 32'(bus.mem_owner_game), 32'(m_owner >= 0));
      check("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
      check("abort", 32'(bus.abort), 32'(e_abort));
      check("frame_count", 32'(bus.frame_count), 32'(e_count));
    end
  end

  // ---------------- stimulus helpers ----------------
  int gcnt [NR];

  task automatic drive(input int row, input logic [3:0] rq, input logic [3:0] dn);
    @(negedge clk);
    bus.rowPos = 10'(row);
    bus.colPos = 10'($urandom_range(0, 799));
    bus.req    = rq;
    bus.done   = dn;
  endtask

  // Engines that strobe done on their third granted cycle.
  task automatic drive_auto(input int row, input logic [3:0] rq);
    logic [3:0] dn;
    @(negedge clk);
    dn = 4'b0000;
    for (int i = 0; i < NR; i++) begin
      if (bus.gnt[i]) gcnt[i]++;
      else            gcnt[i] = 0;
      dn[i] = (gcnt[i] == 3);
    end
    bus.rowPos = 10'(row);
    bus.colPos = 10'($urandom_range(0, 799));
    bus.req    = rq;
    bus.done   = dn;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic int oh2i(input logic [3:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  initial begin
    int order[$];
    int runs[$];
    int gaps[$];
    int run, gap, phase, hi, lo, row;
    bit found;
    logic [3:0] g, pg, rq, dn;

    bus.rowPos = 10'd100;
    bus.colPos = 10'd0;
    bus.req    = 4'b0000;
    bus.done   = 4'b0000;
    for (int i = 0; i < NR; i++) gcnt[i] = 0;

    // Reset mid active video, then sweep to blanking.
    #2;
    chk_en = 1'b1;
    reset  = 1'b1;
    #2;
    check("t1_reset_gnt", 32'(bus.gnt), 32'd0);
    check("t1_reset_count", 32'(bus.frame_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int r = 100; r < VA; r++) drive(r, 4'($urandom_range(0, 15)), 4'b0000);
    drive(VA, 4'b0000, 4'b0000);
    after_edge();
    check("t1_tick", 32'(bus.frame_tick), 32'd1);
    check("t1_count", 32'(bus.frame_count), 32'd1);

    // All four engines requesting, each finishing after three cycles.
    run = 0; gap = 0; pg = 4'b0000;
    for (int c = 0; c < 80 && runs.size() < 5; c++) begin
      drive_auto(485, 4'hF);
      g = bus.gnt;
      if (g != 4'b0000) begin
        if (pg == 4'b0000) begin
          order.push_back(oh2i(g));
          if (order.size() > 1) gaps.push_back(gap);
        end
        run++;
        gap = 0;
      end else begin
        if (pg != 4'b0000) begin
          runs.push_back(run);
          run = 0;
        end
        gap++;
      end
      pg = g;
    end
    check("t2_num_grants", 32'(order.size()), 32'd5);
    if (order.size() >= 5 && runs.size() >= 5 && gaps.size() >= 4) begin
      check("t2_order0", 32'(order[0]), 32'd0);
      check("t2_order1", 32'(order[1]), 32'd1);
      check("t2_order2", 32'(order[2]), 32'd2);
      check("t2_order3", 32'(order[3]), 32'd3);
      check("t2_order4", 32'(order[4]), 32'd0);
      for (int i = 0; i < 4; i++) begin
        check("t2_run_len", 32'(runs[i]), 32'd3);
        check("t2_gap_len", 32'(gaps[i]), 32'd1);
      end
    end

    // Single requester never finishing: preempted after the burst limit.
    pg = bus.gnt; phase = 0; hi = 0; lo = 0;
    for (int c = 0; c < 300 && phase < 3; c++) begin
      drive(485, 4'b0001, 4'b0000);
      g = bus.gnt;
      case (phase)
        0: if (pg == 4'b0000 && g == 4'b0001) begin phase = 1; hi = 1; end
        1: if (g == 4'b0001) hi++; else begin phase = 2; lo = 1; end
        2: if (g == 4'b0000) lo++; else phase = 3;
        default: ;
      endcase
      pg = g;
    end
    check("t3_regranted", 32'(phase), 32'd3);
    check("t3_burst_len", 32'(hi), 32'(MB));
    check("t3_gap_len", 32'(lo), 32'd1);

    // Active video resumes under a grant: abort, then normal-completion variant.
    pg = bus.gnt; found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      drive(523, 4'b0001, 4'b0000);
      g = bus.gnt;
      found = (pg == 4'b0000 && g == 4'b0001);
      pg = g;
    end
    check("t4_grant_seen", 32'(found), 32'd1);
    drive(VT - 1, 4'b0001, 4'b0000);
    drive(0, 4'b0001, 4'b0000);
    after_edge();
    check("t4_abort", 32'(bus.abort), 32'd1);
    check("t4_gnt_off", 32'(bus.gnt), 32'd0);
    check("t4_owner_off", 32'(bus.mem_owner_game), 32'd0);
    drive(1, 4'b0001, 4'b0000);
    after_edge();
    check("t4_abort_pulse", 32'(bus.abort), 32'd0);
    drive(200, 4'b0001, 4'b0000);
    drive(VA - 1, 4'b0001, 4'b0000);
    drive(VA, 4'b0001, 4'b0000);
    pg = bus.gnt; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      drive(481, 4'b0001, 4'b0000);
      g = bus.gnt;
      found = (pg == 4'b0000 && g == 4'b0001);
      pg = g;
    end
    check("t4b_grant_seen", 32'(found), 32'd1);
    drive(VT - 1, 4'b0001, 4'b0000);
    drive(0, 4'b0001, 4'b0001);
    after_edge();
    check("t4b_abort", 32'(bus.abort), 32'd0);
    check("t4b_gnt_off", 32'(bus.gnt), 32'd0);

    // Request first seen on the last line waits for the next blank entry.
    drive(300, 4'b0000, 4'b0000);
    drive(VA, 4'b0000, 4'b0000);
    repeat (3) drive(490, 4'b0000, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      drive(VT - 1, 4'b0001, 4'b0000);
      after_edge();
      check("t5_no_grant", 32'(bus.gnt), 32'd0);
    end
    drive(0, 4'b0001, 4'b0000);
    drive(VA - 1, 4'b0001, 4'b0000);
    drive(VA, 4'b0001, 4'b0000);
    after_edge();
    check("t5_tick", 32'(bus.frame_tick), 32'd1);
    drive(481, 4'b0001, 4'b0000);
    after_edge();
    check("t5_grant", 32'(bus.gnt), 32'b0001);

    // Reset under a grant to engine 2 in blanking.
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      drive(485, 4'b0100, 4'b0000);
      found = (bus.gnt == 4'b0100);
    end
    check("t6_grant2_seen", 32'(found), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_reset_gnt", 32'(bus.gnt), 32'd0);
    check("t6_reset_owner", 32'(bus.mem_owner_game), 32'd0);
    repeat (2) drive(490, 4'hF, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(490 + c, 4'hF, 4'b0000);
      after_edge();
      check("t6_no_grant", 32'(bus.gnt), 32'd0);
    end
    drive(100, 4'hF, 4'b0000);
    drive(VA, 4'hF, 4'b0000);
    drive(481, 4'hF, 4'b0000);
    after_edge();
    check("t6_first_grant", 32'(bus.gnt), 32'b0001);

    // Random raster walk, requests, done strobes and occasional resets.
    row = 481; rq = 4'hF;
    for (int c = 0; c < 4000; c++) begin
      if (row >= VA) row = row + $urandom_range(0, 2);
      else           row = row + $urandom_range(0, 60);
      if (row >= VT) row = row - VT;
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 15) == 0) rq[i] = ~rq[i];
      for (int i = 0; i < NR; i++) dn[i] = ($urandom_range(0, 3) == 0);
      drive(row, rq, dn);
      reset = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) drive(100, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
